sa_rwsp_fifo_ctrl: RTL and testbench

//  Valid/ready FIFO controller that drives one external sa_ram_rwsp_256x16 instance.

---
 rtl/sa_rwsp_fifo_pkg.sv | 10 +
 rtl/sa_rwsp_fifo_obuf.sv | 39 +++
 rtl/sa_rwsp_fifo_ctrl.sv | 77 +++++++
 tb/tb_sa_rwsp_fifo_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/sa_rwsp_fifo_pkg.sv
// sa_rwsp_fifo_pkg: shared defaults and helpers for the RWSP-RAM-backed FIFO controller.
package sa_rwsp_fifo_pkg;
  localparam int AW_DEF     = 8;
  localparam int DW_DEF     = 16;
  localparam int OBUF_MIN   = 4;
  localparam int RAM_RD_LAT = 2;
  function automatic int lvl_w(input int aw);
    return aw + 4;
  endfunction
endpackage

// File: rtl/sa_rwsp_fifo_obuf.sv
// sa_rwsp_fifo_obuf: small first-word-fall-through register queue fed by RAM read data.
module sa_rwsp_fifo_obuf #(
  parameter  int DW   = 16,
  parameter  int OBUF = 4,
  localparam int CW   = $clog2(OBUF + 1),
  localparam int IW   = $clog2(OBUF)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic          out_pvld,
  output logic [DW-1:0] out_pd,
  output logic [CW-1:0] cnt
);
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_mem [OBUF];
  logic [IW-1:0] w_wr_idx;
  // head is always entry 0; a pop shifts, and a same-cycle write lands one slot lower
  assign w_wr_idx = IW'(r_cnt - CW'(rd_en));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      for (int i = 0; i < OBUF; i++) r_mem[i] <= '0;
    end else begin
      if (rd_en) for (int i = 0; i < OBUF - 1; i++) r_mem[i] <= r_mem[i+1];
      if (wr_en) r_mem[w_wr_idx] <= wr_data;
      r_cnt <= r_cnt + CW'(wr_en) - CW'(rd_en);
    end
  end
  assign out_pvld = r_cnt != '0;
  assign out_pd   = r_mem[0];
  assign cnt      = r_cnt;
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(wr_en && !rd_en && r_cnt == CW'(OBUF)));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(rd_en && r_cnt == '0));
endmodule

// File: rtl/sa_rwsp_fifo_ctrl.sv
// sa_rwsp_fifo_ctrl: valid/ready FIFO controller driving an external 2-stage-read RWSP RAM.
module sa_rwsp_fifo_ctrl
  import sa_rwsp_fifo_pkg::*;
#(
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF,
  parameter int OBUF = OBUF_MIN
) (
  input  logic                 nvdla_core_clk,
  input  logic                 nvdla_core_rstn,
  input  logic                 in_pvld,
  output logic                 in_prdy,
  input  logic [DW-1:0]        in_pd,
  output logic                 out_pvld,
  input  logic                 out_prdy,
  output logic [DW-1:0]        out_pd,
  output logic [AW-1:0]        ram_wa,
  output logic                 ram_we,
  output logic [DW-1:0]        ram_di,
  output logic [AW-1:0]        ram_ra,
  output logic                 ram_re,
  output logic                 ram_ore,
  input  logic [DW-1:0]        ram_dout,
  output logic [lvl_w(AW)-1:0] level
);
  localparam int LW = lvl_w(AW);
  localparam int CW = $clog2(OBUF + 1);
  logic [AW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [AW:0]           r_ram_cnt, w_ram_cnt_nxt;
  logic [RAM_RD_LAT-1:0] r_v, w_v_nxt;
  logic                  r_in_prdy;
  logic [LW-1:0]         r_level;
  logic [CW-1:0]         w_ob_cnt, w_ob_nxt;
  logic                  w_push, w_pop, w_issue;
  assign w_push = in_pvld & r_in_prdy;
  assign w_pop  = out_pvld & out_prdy;
  // every in-flight read already owns an obuf slot, so capture can never overflow
  assign w_issue       = (r_ram_cnt != '0) && (int'(w_ob_cnt) + $countones(r_v) < OBUF);
  assign w_ram_cnt_nxt = r_ram_cnt + (AW+1)'(w_push) - (AW+1)'(w_issue);
  assign w_v_nxt       = {r_v[RAM_RD_LAT-2:0], w_issue};
  assign w_ob_nxt      = w_ob_cnt + CW'(r_v[RAM_RD_LAT-1]) - CW'(w_pop);
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_ram_cnt <= '0;
      r_v       <= '0;
      r_in_prdy <= 1'b0;
      r_level   <= '0;
    end else begin
      r_wr_ptr  <= r_wr_ptr + AW'(w_push);
      r_rd_ptr  <= r_rd_ptr + AW'(w_issue);
      r_ram_cnt <= w_ram_cnt_nxt;
      r_v       <= w_v_nxt;
      r_in_prdy <= w_ram_cnt_nxt != (AW+1)'(2**AW);
      r_level   <= LW'(w_ram_cnt_nxt) + LW'($countones(w_v_nxt)) + LW'(w_ob_nxt);
    end
  end
  assign in_prdy = r_in_prdy;
  assign ram_we  = w_push;
  assign ram_wa  = r_wr_ptr;
  assign ram_di  = in_pd;
  assign ram_re  = w_issue;
  assign ram_ra  = r_rd_ptr;
  assign ram_ore = r_v[0];
  assign level   = r_level;
  sa_rwsp_fifo_obuf #(.DW(DW), .OBUF(OBUF)) u_obuf (
    .clk      (nvdla_core_clk),
    .rst_n    (nvdla_core_rstn),
    .wr_en    (r_v[RAM_RD_LAT-1]),
    .wr_data  (ram_dout),
    .rd_en    (w_pop),
    .out_pvld (out_pvld),
    .out_pd   (out_pd),
    .cnt      (w_ob_cnt)
  );
endmodule

// File: tb/tb_sa_rwsp_fifo_ctrl.sv
// tb_sa_rwsp_fifo_ctrl: directed vector table plus corner sequences, with a RAM model and a scoreboard.
module tb_sa_rwsp_fifo_ctrl;
  logic        clk = 1'b0, rstn = 1'b0, in_pvld = 1'b0, out_prdy = 1'b0;
  logic [15:0] in_pd = '0;
  logic        in_prdy, out_pvld, ram_we, ram_re, ram_ore;
  logic [15:0] out_pd, ram_di, ram_dout, ram_stage;
  logic [7:0]  ram_wa, ram_ra;
  logic [11:0] level;
  logic [15:0] mem [256];
  logic [15:0] sb [$];
  logic        got;
  int          n_tests = 0, n_fail = 0, nxt, sent, waited;

  typedef struct {
    logic pvld; logic [15:0] pd; logic prdy;
    logic e_iprdy, e_opvld; logic [15:0] e_opd; logic e_we, e_re, e_ore; logic [11:0] e_lvl;
  } vec_t;
  vec_t tv [14];

  always #5 clk = ~clk;

  sa_rwsp_fifo_ctrl dut (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
    .in_pvld(in_pvld), .in_prdy(in_prdy), .in_pd(in_pd),
    .out_pvld(out_pvld), .out_prdy(out_prdy), .out_pd(out_pd),
    .ram_wa(ram_wa), .ram_we(ram_we), .ram_di(ram_di),
    .ram_ra(ram_ra), .ram_re(ram_re), .ram_ore(ram_ore),
    .ram_dout(ram_dout), .level(level)
  );

  // RAM: re latches the addressed word, ore moves it to the output register
  always @(posedge clk) begin
    if (ram_we) mem[ram_wa] <= ram_di;
    if (ram_re) ram_stage <= mem[ram_ra];
    if (ram_ore) ram_dout <= ram_stage;
  end

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rstn) sb.delete();
    else begin
      chk("level_vs_sb", 32'(level), 32'(sb.size()));
      chk("obuf_bound", 32'(dut.w_ob_cnt <= 3'd4), 32'd1);
      if (in_pvld && in_prdy) sb.push_back(in_pd);
      if (out_pvld && out_prdy) begin
        chk("pop_has_data", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) chk("pop_data", 32'(out_pd), 32'(sb.pop_front()));
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 12'd0};
    tv[1]  = '{1'b1, 16'hA5A5, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 12'd0};
    tv[2]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 12'd1};
    tv[3]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 12'd1};
    tv[4]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 12'd1};
    tv[5]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'hA5A5, 1'b0, 1'b0, 1'b0, 12'd1};
    tv[6]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 12'd0};
    tv[7]  = '{1'b1, 16'h0001, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 12'd0};
    tv[8]  = '{1'b1, 16'h0002, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 12'd1};
    tv[9]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 12'd2};
    tv[10] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 12'd2};
    tv[11] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 12'd2};
    tv[12] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0, 12'd1};
    tv[13] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 12'd0};

    repeat (3) cyc();
    chk("rst_in_prdy", 32'(in_prdy), 0);
    chk("rst_out_pvld", 32'(out_pvld), 0);
    chk("rst_level", 32'(level), 0);
    rstn = 1'b1;

    // single word latency and push coinciding with the last RAM word issue
    for (int i = 0; i < 14; i++) begin
      in_pvld = tv[i].pvld; in_pd = tv[i].pd; out_prdy = tv[i].prdy;
      #1;
      chk($sformatf("v%0d_in_prdy", i), 32'(in_prdy), 32'(tv[i].e_iprdy));
      chk($sformatf("v%0d_out_pvld", i), 32'(out_pvld), 32'(tv[i].e_opvld));
      if (tv[i].e_opvld) chk($sformatf("v%0d_out_pd", i), 32'(out_pd), 32'(tv[i].e_opd));
      chk($sformatf("v%0d_ram_we", i), 32'(ram_we), 32'(tv[i].e_we));
      chk($sformatf("v%0d_ram_re", i), 32'(ram_re), 32'(tv[i].e_re));
      chk($sformatf("v%0d_ram_ore", i), 32'(ram_ore), 32'(tv[i].e_ore));
      chk($sformatf("v%0d_level", i), 32'(level), 32'(tv[i].e_lvl));
      cyc();
    end

    // fill until full: 256 in RAM plus 4 in obuf, then drain gap-free in order
    out_prdy = 1'b0; in_pvld = 1'b1; nxt = 0;
    for (int c = 0; c < 400; c++) begin
      in_pd = 16'(nxt); got = in_prdy;
      cyc();
      if (got) nxt++;
      if (!in_prdy) break;
    end
    in_pd = 16'hDEAD;
    #1;
    chk("full_no_write", 32'(ram_we), 0);
    chk("full_accepted", 32'(nxt), 260);
    chk("full_level", 32'(level), 260);
    cyc();
    chk("full_in_prdy", 32'(in_prdy), 0);
    chk("full_level_hold", 32'(level), 260);
    in_pvld = 1'b0; out_prdy = 1'b1;
    for (int i = 0; i < 260; i++) begin
      chk("drain_pvld", 32'(out_pvld), 1);
      chk("drain_pd", 32'(out_pd), 32'(i));
      cyc();
    end
    chk("drain_empty", 32'(out_pvld), 0);
    chk("drain_level", 32'(level), 0);

    // streaming, pointers wrap several times
    for (int c = 0; c < 1004; c++) begin
      in_pvld = c < 1000; in_pd = 16'(1000 + c);
      if (c < 1000) chk("stream_in_prdy", 32'(in_prdy), 1);
      if (c >= 4) begin
        chk("stream_pvld", 32'(out_pvld), 1);
        chk("stream_pd", 32'(16'(1000 + c - 4)), 32'(out_pd));
      end
      cyc();
    end
    in_pvld = 1'b0;
    chk("stream_end_pvld", 32'(out_pvld), 0);
    chk("stream_end_level", 32'(level), 0);

    // random backpressure against the scoreboard
    sent = 0;
    for (int c = 0; c < 5000 && sent < 600; c++) begin
      in_pvld = 1'b1; in_pd = 16'(5000 + sent); out_prdy = 1'($urandom_range(0, 1));
      got = in_prdy;
      cyc();
      if (got) sent++;
    end
    in_pvld = 1'b0; out_prdy = 1'b1;
    chk("rand_sent", 32'(sent), 600);
    for (int c = 0; c < 2000 && level != 0; c++) cyc();
    chk("rand_level_drained", 32'(level), 0);
    chk("rand_sb_empty", 32'(sb.size()), 0);
    cyc();

    // reset with reads in flight and data in obuf
    out_prdy = 1'b0; in_pvld = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_pd = 16'(16'h0B00 + k);
      chk("rst6_push_rdy", 32'(in_prdy), 1);
      cyc();
    end
    in_pvld = 1'b0;
    cyc();
    chk("rst6_pre_ore", 32'(ram_ore), 1);
    chk("rst6_pre_pvld", 32'(out_pvld), 1);
    chk("rst6_pre_level", 32'(level), 4);
    in_pvld = 1'b1;
    #2;
    rstn = 1'b0;
    #1;
    chk("rst6_in_prdy", 32'(in_prdy), 0);
    chk("rst6_out_pvld", 32'(out_pvld), 0);
    chk("rst6_level", 32'(level), 0);
    chk("rst6_ram_we", 32'(ram_we), 0);
    chk("rst6_ram_re", 32'(ram_re), 0);
    chk("rst6_ram_ore", 32'(ram_ore), 0);
    in_pvld = 1'b0;
    repeat (2) cyc();
    rstn = 1'b1; in_pd = 16'h1234;
    chk("rst6_rel_prdy0", 32'(in_prdy), 0);
    cyc();
    chk("rst6_rel_prdy1", 32'(in_prdy), 1);
    in_pvld = 1'b1; out_prdy = 1'b1;
    cyc();
    in_pvld = 1'b0;
    waited = 0;
    for (int c = 0; c < 10 && !out_pvld; c++) begin
      cyc();
      waited++;
    end
    chk("rst6_first_pvld", 32'(out_pvld), 1);
    chk("rst6_first_pd", 32'(out_pd), 32'h1234);
    chk("rst6_latency", 32'(waited), 3);
    cyc();
    chk("rst6_final_level", 32'(level), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
